// File: rtl/div_iter.sv
// div_iter: iterative restoring divider for the EX stage, one quotient bit
// per clock. Result layout is {remainder, quotient} to match HI/LO writes.
// Optional feature macro: DIV_SIGNED_EN enables signed (DIV) operation;
// without it signed_i is ignored and every division is unsigned.
//
// Handshake: EX holds start_i high from request until it has consumed the
// result. ready_o is high in END with result_o stable; EX drops start_i to
// release it, and the block returns to FREE on the next edge. busy_o is high
// while a division is in flight (BYZERO, ON). annul_i aborts an in-flight
// division back to FREE and is ignored once the result is presented.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] work, work_step;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;
  logic             accept;
  logic             unused_bits;

  assign accept = start_i && !annul_i;
  assign quo    = work[WIDTH-1:0];
  assign rem    = work[2*WIDTH-1:WIDTH];

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  // Operand magnitudes for the unsigned core
  always_comb begin
    mag1 = opdata1_i;
    mag2 = opdata2_i;
    if (signed_i && opdata1_i[WIDTH-1]) mag1 = ~opdata1_i + 1'b1;
    if (signed_i && opdata2_i[WIDTH-1]) mag2 = ~opdata2_i + 1'b1;
  end

  // Remember which result halves need negating at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == FREE && accept) begin
      neg_q <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      neg_r <= signed_i & opdata1_i[WIDTH-1];
    end
  end

  assign quo_fix     = neg_q ? (~quo + 1'b1) : quo;
  assign rem_fix     = neg_r ? (~rem + 1'b1) : rem;
  // Top work bit is always zero after a kept subtraction; never read
  assign unused_bits = work[2*WIDTH];
`else
  assign mag1        = opdata1_i;
  assign mag2        = opdata2_i;
  assign quo_fix     = quo;
  assign rem_fix     = rem;
  assign unused_bits = ^{work[2*WIDTH], signed_i};
`endif

  // One restoring step: shift left, trial-subtract, keep if non-negative
  always_comb begin
    diff = work[2*WIDTH-1:WIDTH-1] - {1'b0, divisor_q};
    if (!diff[WIDTH]) work_step = {diff, work[WIDTH-2:0], 1'b1};
    else              work_step = {work[2*WIDTH-1:0], 1'b0};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_n;
  end

  // Next-state logic; annul beats completion in BYZERO and ON
  always_comb begin
    state_n = state;
    case (state)
      FREE:    if (accept) state_n = (opdata2_i == '0) ? BYZERO : ON;
      BYZERO:  state_n = annul_i ? FREE : END;
      ON: begin
        if (annul_i)          state_n = FREE;
        else if (cnt == LAST) state_n = END;
      end
      END:     if (!start_i) state_n = FREE;
      default: state_n = FREE;
    endcase
  end

  // Datapath: latch operands, iterate, finalise and release the result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      work      <= '0;
      divisor_q <= '0;
      result_o  <= '0;
    end else begin
      case (state)
        FREE: begin
          if (accept) begin
            work      <= {{(WIDTH+1){1'b0}}, mag1};
            divisor_q <= mag2;
            cnt       <= '0;
          end
        end
        ON: begin
          if (!annul_i) begin
            if (cnt != LAST) begin
              work <= work_step;
              cnt  <= cnt + 1'b1;
            end else begin
              result_o <= {rem_fix, quo_fix};
            end
          end
        end
        END:     if (!start_i) result_o <= '0;
        default: ;
      endcase
    end
  end

  assign ready_o   = (state == END);
  assign busy_o    = (state == BYZERO) || (state == ON);
  assign dbg_state = state;

endmodule
